// File: rtl/bitcoin_hash_axis.sv
`default_nettype none
// ============================================================================
// Module  : bitcoin_hash_axis
// Brief   : AXI-Stream Bitcoin header double-SHA-256 engine, one round/cycle.
// Revision: 1.0
// ============================================================================
module bitcoin_hash_axis (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast
);

    localparam logic [2:0] c_LOAD = 3'd0;
    localparam logic [2:0] c_H1B0 = 3'd1;
    localparam logic [2:0] c_H1B1 = 3'd2;
    localparam logic [2:0] c_H2   = 3'd3;
    localparam logic [2:0] c_OUT  = 3'd4;

    localparam logic [31:0] c_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] f_rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] f_bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [4:0]  r_cnt;
    logic [6:0]  r_rnd;
    logic [2:0]  r_ocnt;
    logic [31:0] r_hdr [0:19];
    logic [31:0] r_w   [0:15];
    logic [31:0] r_hc  [0:7];
    logic [31:0] r_v   [0:7];
    logic [31:0] w_sum [0:7];
    logic [31:0] w_nblk[0:15];

    logic        w_accept, w_last_beat, w_hashing, w_ff, w_ohs, w_olast;
    logic [31:0] w_s1, w_ch, w_t1, w_s0, w_maj, w_t2, w_sg0, w_sg1, w_wnew;
    logic        w_unused;

    assign w_unused    = s_axis_tlast;
    assign w_accept    = s_axis_tvalid && s_axis_tready;
    assign w_last_beat = w_accept && (r_cnt == 5'd19);
    assign w_hashing   = (r_state == c_H1B0) || (r_state == c_H1B1) || (r_state == c_H2);
    assign w_ff        = w_hashing && (r_rnd == 7'd64);
    assign w_ohs       = (r_state == c_OUT) && m_axis_tready;
    assign w_olast     = w_ohs && (r_ocnt == 3'd7);

    // Round logic: r_v holds a..h, r_w[0] is W[t] of a sliding 16-word schedule
    assign w_s1  = f_rotr(r_v[4], 6) ^ f_rotr(r_v[4], 11) ^ f_rotr(r_v[4], 25);
    assign w_ch  = (r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]);
    assign w_t1  = r_v[7] + w_s1 + w_ch + c_K[r_rnd[5:0]] + r_w[0];
    assign w_s0  = f_rotr(r_v[0], 2) ^ f_rotr(r_v[0], 13) ^ f_rotr(r_v[0], 22);
    assign w_maj = (r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]);
    assign w_t2  = w_s0 + w_maj;
    assign w_sg0 = f_rotr(r_w[1], 7) ^ f_rotr(r_w[1], 18) ^ (r_w[1] >> 3);
    assign w_sg1 = f_rotr(r_w[14], 17) ^ f_rotr(r_w[14], 19) ^ (r_w[14] >> 10);
    assign w_wnew = w_sg1 + r_w[9] + w_sg0 + r_w[0];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_sum[i] = r_hc[i] + r_v[i];
        end
    end

    // Message block loaded when the current state finishes its compression
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_nblk[i] = r_hdr[i];
        end
        case (r_state)
            c_H1B0: begin
                for (int i = 0; i < 16; i++) begin
                    w_nblk[i] = 32'h0;
                end
                for (int i = 0; i < 4; i++) begin
                    w_nblk[i] = r_hdr[16 + i];
                end
                w_nblk[4]  = 32'h8000_0000;
                w_nblk[15] = 32'd640;
            end
            c_H1B1: begin
                for (int i = 0; i < 16; i++) begin
                    w_nblk[i] = 32'h0;
                end
                for (int i = 0; i < 8; i++) begin
                    w_nblk[i] = w_sum[i];
                end
                w_nblk[8]  = 32'h8000_0000;
                w_nblk[15] = 32'd256;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= c_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_LOAD: if (w_last_beat) w_next = c_H1B0;
            c_H1B0: if (w_ff)        w_next = c_H1B1;
            c_H1B1: if (w_ff)        w_next = c_H2;
            c_H2:   if (w_ff)        w_next = c_OUT;
            c_OUT:  if (w_olast)     w_next = c_LOAD;
            default:                 w_next = c_LOAD;
        endcase
    end

    always_comb begin
        s_axis_tready = aresetn && (r_state == c_LOAD);
        m_axis_tvalid = (r_state == c_OUT);
        m_axis_tlast  = (r_state == c_OUT) && (r_ocnt == 3'd7);
        m_axis_tdata  = (r_state == c_OUT) ? f_bswap(r_hc[r_ocnt]) : 32'h0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_cnt  <= 5'd0;
            r_rnd  <= 7'd0;
            r_ocnt <= 3'd0;
        end else begin
            if (w_accept) begin
                r_hdr[r_cnt] <= f_bswap(s_axis_tdata);
                r_cnt        <= (r_cnt == 5'd19) ? 5'd0 : r_cnt + 5'd1;
            end
            if (w_last_beat) begin
                r_rnd <= 7'd0;
                for (int i = 0; i < 16; i++) begin
                    r_w[i] <= w_nblk[i];
                end
                for (int i = 0; i < 8; i++) begin
                    r_hc[i] <= c_IV[i];
                    r_v[i]  <= c_IV[i];
                end
            end else if (w_hashing) begin
                if (w_ff) begin
                    // Feed-forward cycle also seeds the next compression
                    r_rnd <= 7'd0;
                    for (int i = 0; i < 16; i++) begin
                        r_w[i] <= w_nblk[i];
                    end
                    for (int i = 0; i < 8; i++) begin
                        r_hc[i] <= (r_state == c_H1B1) ? c_IV[i] : w_sum[i];
                        r_v[i]  <= (r_state == c_H1B1) ? c_IV[i] : w_sum[i];
                    end
                end else begin
                    r_rnd  <= r_rnd + 7'd1;
                    r_v[0] <= w_t1 + w_t2;
                    r_v[1] <= r_v[0];
                    r_v[2] <= r_v[1];
                    r_v[3] <= r_v[2];
                    r_v[4] <= r_v[3] + w_t1;
                    r_v[5] <= r_v[4];
                    r_v[6] <= r_v[5];
                    r_v[7] <= r_v[6];
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i + 1];
                    end
                    r_w[15] <= w_wnew;
                end
            end
            if (w_ohs) begin
                r_ocnt <= r_ocnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitcoin_hash_axis.sv
`default_nettype none
// ============================================================================
// Module  : tb_bitcoin_hash_axis
// Brief   : Self-checking bench against a software double-SHA-256 model.
// Revision: 1.0
// ============================================================================
module tb_bitcoin_hash_axis;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    bitcoin_hash_axis dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    localparam logic [31:0] c_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [639:0] c_HDR = {
        32'h02000000,
        256'h671D0E2FF45DD1E927A51219D1CA1065C93B0C4E8840290A0000000000000000,
        256'h2CD900FC3513260DF5BD2EABFD456CD2B3D2BACE30CC078215A907C045F4992E,
        32'h74749054, 32'h747B1B18, 32'h43F740C0};

    int npass = 0;
    int ntot  = 0;
    int ndig  = 0;
    int ndig_exp = 0;
    int rmode = 0;
    logic [32:0] expq[$];

    task automatic check(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
        ntot++;
        if (ok) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook FIPS 180-4 SHA-256 over an arbitrary byte string
    function automatic logic [255:0] sha256(input logic [7:0] m[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        logic [31:0] h[8];
        logic [31:0] w[64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        for (int i = 0; i < 8; i++) h[i] = c_IV[i];
        for (int blk = 0; blk < p.size() / 64; blk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[blk*64+4*t], p[blk*64+4*t+1], p[blk*64+4*t+2], p[blk*64+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + c_K[t] + w[t];
                t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    function automatic logic [255:0] dsha_hdr(input logic [639:0] hdr);
        logic [7:0]   q[$];
        logic [255:0] d1;
        for (int k = 0; k < 80; k++) q.push_back(hdr[639-8*k -: 8]);
        d1 = sha256(q);
        q.delete();
        for (int j = 0; j < 32; j++) q.push_back(d1[255-8*j -: 8]);
        return sha256(q);
    endfunction

    // Output beat i carries digest bytes 4i..4i+3, earliest byte in [7:0]
    function automatic logic [31:0] beat_of(input logic [255:0] dg, input int i);
        return {dg[255-8*(4*i+3) -: 8], dg[255-8*(4*i+2) -: 8],
                dg[255-8*(4*i+1) -: 8], dg[255-8*(4*i) -: 8]};
    endfunction

    task automatic send_header(input logic [639:0] hdr, input bit gaps, input int nbeats);
        logic [255:0] dg;
        int n;
        int lat;
        for (int bt = 0; bt < nbeats; bt++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge aclk);
                    s_axis_tvalid = 1'b0;
                    s_axis_tdata  = $urandom;
                end
            end
            @(negedge aclk);
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (bt == 19);
            s_axis_tdata  = {hdr[639-8*(4*bt+3) -: 8], hdr[639-8*(4*bt+2) -: 8],
                             hdr[639-8*(4*bt+1) -: 8], hdr[639-8*(4*bt) -: 8]};
            n = 0;
            while (s_axis_tready !== 1'b1) begin
                @(negedge aclk);
                n++;
                if (n > 3000) begin
                    $display("FAIL input_accept_timeout: got no tready expected tready");
                    $fatal(1, "input stuck");
                end
            end
            @(posedge aclk);
        end
        if (nbeats == 20) begin
            dg = dsha_hdr(hdr);
            for (int i = 0; i < 8; i++) expq.push_back({(i == 7), beat_of(dg, i)});
            ndig_exp++;
        end
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        lat = 1;
        if (nbeats == 20) begin
            while (m_axis_tvalid !== 1'b1 && lat <= 210) begin
                @(negedge aclk);
                lat++;
            end
            check(lat <= 210, "latency", lat, 210);
        end
    endtask

    // Downstream ready generation plus the single output compare process
    initial begin
        int  rc = 0;
        bit  pend = 0;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge aclk);
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (rc % 8) >= 2;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            rc++;
            if (aresetn === 1'b1) begin
                if (m_axis_tvalid === 1'b1) begin
                    if (expq.size() == 0) begin
                        check(0, "unexpected_beat", m_axis_tdata, 0);
                    end else begin
                        check(m_axis_tdata == expq[0][31:0], "tdata", m_axis_tdata, expq[0][31:0]);
                        check(m_axis_tlast == expq[0][32], "tlast", m_axis_tlast, expq[0][32]);
                        if (m_axis_tready) begin
                            if (m_axis_tlast) ndig++;
                            void'(expq.pop_front());
                        end
                    end
                end else if (pend) begin
                    check(0, "tvalid_drop", 0, 1);
                end
                pend = (m_axis_tvalid === 1'b1) && !m_axis_tready;
                if (s_axis_tready === 1'b1)
                    check(expq.size() == 0 && m_axis_tvalid !== 1'b1, "accept_while_busy", expq.size(), 0);
            end else begin
                pend = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   q[$];
        logic [255:0] dg;
        logic [639:0] rh;
        int n;

        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tlast  = 1'b0;

        // Pin the model to published vectors
        q = '{8'h61, 8'h62, 8'h63};
        check(sha256(q) == 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
              "model_abc", sha256(q), 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        q.delete();
        check(sha256(q) == 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855,
              "model_empty", sha256(q), 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
        dg = dsha_hdr(c_HDR);
        check(beat_of(dg, 6) == 32'h0, "model_beat6", beat_of(dg, 6), 0);
        check(beat_of(dg, 7) == 32'h0, "model_beat7", beat_of(dg, 7), 0);

        repeat (3) @(negedge aclk);
        check(s_axis_tready == 1'b0, "rst_s_tready", s_axis_tready, 0);
        check(m_axis_tvalid == 1'b0, "rst_m_tvalid", m_axis_tvalid, 0);
        check(m_axis_tlast == 1'b0, "rst_m_tlast", m_axis_tlast, 0);
        check(m_axis_tdata == 32'h0, "rst_m_tdata", m_axis_tdata, 0);
        aresetn = 1'b1;
        #1;
        check(s_axis_tready == 1'b1, "post_rst_s_tready", s_axis_tready, 1);

        rmode = 0; send_header(c_HDR, 0, 20);
        rmode = 1; send_header(c_HDR, 0, 20);
        rmode = 0; send_header(c_HDR, 1, 20);
        send_header('0, 0, 20);

        // Abort a partial header, then send the full one
        send_header(c_HDR, 0, 11);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check(s_axis_tready == 1'b1, "abort_s_tready", s_axis_tready, 1);
        send_header(c_HDR, 0, 20);

        rmode = 2;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20; i++) rh[32*i +: 32] = $urandom;
            send_header(rh, k[0], 20);
        end

        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check(expq.size() == 0, "drain", expq.size(), 0);
        check(ndig == ndig_exp, "digest_count", ndig, ndig_exp);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
